// File: rtl/spi_memory_core.sv
// SPI mode-0 slave memory core: command/data shifting, address counter and word RAM in one block.
// Optional SPI_BURST_EN: keep transferring words at auto-incremented addresses while cs stays low.
`timescale 1ns/1ps

// state    | meaning
// IDLE     | cs high, waiting for frame start
// GET_CMD  | shifting in address bits and R/W bit
// LOAD     | one clk: fetch mem[addr] into the shift register
// READ     | shifting the word out on miso
// WRITE    | shifting a data word in from mosi
// COMMIT   | one clk: write the received word to mem[addr]
// DONE     | frame finished, ignore sck until cs rises
module spi_memory_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic sck_pe,
  input  logic sck_ne,
  input  logic mosi,
  output logic miso,
  output logic miso_we
);

  localparam int MAX_BITS = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(DEPTH - 1);

`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_GET_CMD, S_LOAD, S_READ, S_WRITE, S_COMMIT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] cmd_sr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic pe, ne;
  logic cmd_shift, cmd_done, wr_shift, wr_done, rd_shift, rd_done;
  logic load_word, commit_word, cnt_clr, cnt_inc, addr_inc;

  // A coincident falling-edge pulse is dropped in favour of the rising edge.
  assign pe = sck_pe;
  assign ne = sck_ne & ~sck_pe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_GET_CMD;
        S_GET_CMD: if (cmd_done) state_nxt = mosi ? S_LOAD : S_WRITE;
        S_LOAD:    state_nxt = S_READ;
        S_READ:    if (rd_done) state_nxt = BURST ? S_LOAD : S_DONE;
        S_WRITE:   if (wr_done) state_nxt = S_COMMIT;
        S_COMMIT:  state_nxt = BURST ? S_WRITE : S_DONE;
        S_DONE:    state_nxt = S_DONE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // COMMIT writes regardless of cs, so a cs rise in that clk still lands the word.
  always_comb begin
    cmd_shift   = 1'b0;
    cmd_done    = 1'b0;
    wr_shift    = 1'b0;
    wr_done     = 1'b0;
    rd_shift    = 1'b0;
    rd_done     = 1'b0;
    load_word   = 1'b0;
    commit_word = 1'b0;
    case (state)
      S_GET_CMD: begin
        cmd_shift = pe;
        cmd_done  = pe && (bit_cnt == CMD_LAST);
      end
      S_LOAD:   load_word = 1'b1;
      S_READ: begin
        rd_shift = ne;
        rd_done  = pe && (bit_cnt == DATA_LAST);
      end
      S_WRITE: begin
        wr_shift = pe;
        wr_done  = pe && (bit_cnt == DATA_LAST);
      end
      S_COMMIT: commit_word = 1'b1;
      default: ;
    endcase
    cnt_clr  = (state == S_IDLE) || cmd_done || load_word || commit_word;
    cnt_inc  = pe && ((state == S_GET_CMD) || (state == S_READ) || (state == S_WRITE));
    addr_inc = BURST && (rd_done || commit_word);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      cmd_sr  <= '0;
      addr    <= '0;
      data_sr <= '0;
      miso    <= 1'b0;
      miso_we <= 1'b0;
    end else begin
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + CNT_W'(1);

      if (cmd_shift) cmd_sr <= ADDR_W'({cmd_sr, mosi});

      if (cmd_done)      addr <= ADDR_W'({1'b0, cmd_sr} % DEPTH_X);
      else if (addr_inc) addr <= (addr == ADDR_MAX) ? '0 : addr + ADDR_W'(1);

      if (load_word)     data_sr <= mem[addr];
      else if (rd_shift) data_sr <= DATA_W'({data_sr, 1'b0});
      else if (wr_shift) data_sr <= DATA_W'({data_sr, mosi});

      if (rd_shift) miso <= data_sr[DATA_W-1];

      miso_we <= (state_nxt == S_LOAD) || (state_nxt == S_READ);
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_word) mem[addr] <= data_sr;
  end

endmodule

// File: tb/tb_spi_memory_core.sv
// Bench for spi_memory_core: directed SPI frames, read data checked by a queue-based monitor.
`timescale 1ns/1ps

module tb_spi_memory_core;

  logic clk = 1'b0;
  logic rst_n, cs, sck_pe, sck_ne, mosi;
  logic miso, miso_we;

  int n_checks = 0;
  int n_pass   = 0;
  int half     = 4;
  logic we_seen = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_sr = 8'h00;
  logic [7:0] exp_b;
  int mon_cnt = 0;

  always #5 clk = ~clk;

  spi_memory_core #(.DATA_W(8), .ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sck_pe(sck_pe), .sck_ne(sck_ne),
    .mosi(mosi), .miso(miso), .miso_we(miso_we)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      we_seen = we_seen | miso_we;
    end
  endtask

  task automatic xfer_bit(input logic b);
    mosi = b;
    tick(half - 1);
    sck_pe = 1'b1;
    tick(1);
    sck_pe = 1'b0;
    tick(half - 1);
    sck_ne = 1'b1;
    tick(1);
    sck_ne = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) xfer_bit(v[7-i]);
  endtask

  task automatic frame_start();
    cs = 1'b0;
    we_seen = 1'b0;
    tick(half);
  endtask

  task automatic frame_end();
    cs = 1'b1;
    tick(2 * half);
  endtask

  task automatic send_cmd(input logic [6:0] a, input logic rw);
    send_byte({a, rw}, 8);
  endtask

  task automatic write_frame(input logic [6:0] a, input logic [7:0] d);
    frame_start();
    send_cmd(a, 1'b0);
    send_byte(d, 8);
    frame_end();
    check("wr_we_low", 32'(we_seen), 32'd0);
  endtask

  task automatic read_frame(input logic [6:0] a, input logic [7:0] d);
    frame_start();
    send_cmd(a, 1'b1);
    exp_q.push_back(d);
    send_byte(8'h00, 8);
    frame_end();
    check("rd_we_high", 32'(we_seen), 32'd1);
  endtask

  // Master samples miso on each sck rising pulse while the slave drives the line.
  always @(negedge clk) begin
    if (!rst_n || cs) begin
      mon_cnt = 0;
    end else if (sck_pe && miso_we) begin
      mon_sr = {mon_sr[6:0], miso};
      mon_cnt++;
      if (mon_cnt == 8) begin
        mon_cnt = 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_unexpected: got %h with nothing pending at %0t", mon_sr, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check("rd_data", 32'(mon_sr), 32'(exp_b));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cs = 1'b1; sck_pe = 1'b0; sck_ne = 1'b0; mosi = 1'b0;
    tick(3);
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_we", 32'(miso_we), 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("idle_miso", 32'(miso), 32'd0);
    check("idle_we", 32'(miso_we), 32'd0);

    write_frame(7'h11, 8'h33);
    write_frame(7'h12, 8'h5A);
    read_frame(7'h12, 8'h5A);

    // aborted write: 4 bits of 0xFF then cs rises
    frame_start();
    send_cmd(7'h12, 1'b0);
    send_byte(8'hFF, 4);
    cs = 1'b1;
    tick(1);
    check("abort_we", 32'(miso_we), 32'd0);
    tick(2 * half);
    check("abort_we_seen", 32'(we_seen), 32'd0);
    read_frame(7'h12, 8'h5A);

`ifdef SPI_BURST_EN
    frame_start();
    send_cmd(7'h7F, 1'b0);
    send_byte(8'h01, 8);
    send_byte(8'h02, 8);
    frame_end();
    check("burst_wr_we", 32'(we_seen), 32'd0);
    frame_start();
    send_cmd(7'h7F, 1'b1);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    send_byte(8'h00, 8);
    send_byte(8'h00, 8);
    check("burst_rd_we", 32'(miso_we), 32'd1);
    frame_end();
    read_frame(7'h00, 8'h02);
    read_frame(7'h11, 8'h33);
`else
    frame_start();
    send_cmd(7'h10, 1'b0);
    send_byte(8'hAA, 8);
    send_byte(8'hBB, 8);
    frame_end();
    check("single_wr_we", 32'(we_seen), 32'd0);
    frame_start();
    send_cmd(7'h10, 1'b1);
    exp_q.push_back(8'hAA);
    send_byte(8'h00, 8);
    check("done_we", 32'(miso_we), 32'd0);
    send_byte(8'h00, 8);
    frame_end();
    read_frame(7'h11, 8'h33);
`endif

    // reset in the middle of reading 0x5A: three bits out, miso now shows bit 4 (1)
    frame_start();
    send_cmd(7'h12, 1'b1);
    send_byte(8'h00, 3);
    check("midread_we", 32'(miso_we), 32'd1);
    check("midread_miso", 32'(miso), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_we", 32'(miso_we), 32'd0);
    cs = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    read_frame(7'h12, 8'h5A);

    // clk at 4x sck, one sck period of cs high between frames
    half = 2;
    write_frame(7'h21, 8'hC3);
    write_frame(7'h22, 8'h3C);
    read_frame(7'h21, 8'hC3);
    read_frame(7'h22, 8'h3C);
    read_frame(7'h12, 8'h5A);

    tick(10);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
